d_mem_ctrl: RTL and testbench

Parametrised data memory for the RV32 core, and the successor to the bare data-memory stub. It accepts one load or store per cycle over a valid/ready request channel and decodes RISC-V funct3 width and sign. It steers byte lanes, sign- or zero-extends loads, and flags misaligned, out-of-range and illegal accesses. An optional zero-clear sequence runs after reset. It sits between the MEM stage and on-chip SRAM.

---
 rtl/d_mem_pkg.sv | 24 ++
 rtl/d_mem_if.sv | 25 ++
 rtl/d_mem_ram.sv | 32 +++
 rtl/d_mem_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_d_mem_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/d_mem_pkg.sv
// rtl/d_mem_pkg.sv - shared funct3 codes, FSM states and byte-enable helper for d_mem_ctrl
package d_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // Size comes from funct3[1:0]; the lane picks which bytes of the word are written.
    function automatic logic [3:0] be_mask(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3[1:0])
            2'b00:   be_mask = 4'b0001 << lane;
            2'b01:   be_mask = lane[1] ? 4'b1100 : 4'b0011;
            default: be_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/d_mem_if.sv
// rtl/d_mem_if.sv - request/response bus between the MEM stage and d_mem_ctrl
interface d_mem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/d_mem_ram.sv
// rtl/d_mem_ram.sv - single-port DEPTHx32 synchronous RAM, byte-enable write, registered read
module d_mem_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [3:0]               be_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/d_mem_ctrl.sv
// rtl/d_mem_ctrl.sv - RV32 data memory controller; D_MEM_ZERO_INIT_EN enables the post-reset zero-clear
module d_mem_ctrl
    import d_mem_pkg::*;
#(
    parameter int                DEPTH     = 1024,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0001_0000,
    parameter int                OUT_REG   = 0
) (
    input  logic   clk,
    input  logic   rst,
    d_mem_if.slave bus
);
    localparam int              WA   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * 4);

`ifdef D_MEM_ZERO_INIT_EN
    localparam state_e RESET_ST = ST_INIT;
`else
    localparam state_e RESET_ST = ST_RUN;
`endif

    state_e            state_q;
    logic              ready_q;
    logic              done_q;
    logic              init_we;
    logic              init_last;
    logic [WA-1:0]     init_addr;

    logic [ADDR_W-1:0] offset;
    logic [WA-1:0]     word_idx;
    logic [1:0]        lane;
    logic              in_range;
    logic              misaligned;
    logic              illegal;
    logic              req_err;
    logic              accept;
    logic [31:0]       st_data;

    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [WA-1:0]     ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic              s1_valid_q;
    logic              s1_err_q;
    logic              s1_load_q;
    logic [2:0]        s1_f3_q;
    logic [1:0]        s1_lane_q;
    logic [31:0]       shifted;
    logic [31:0]       ld_data;
    logic [31:0]       s1_rdata;

    always_comb begin
        offset     = bus.req_addr - BASE_ADDR;
        word_idx   = offset[WA+1:2];
        lane       = offset[1:0];
        in_range   = (bus.req_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
                  || ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        illegal    = bus.req_we ? (bus.req_funct3 > F3_W)
                                : (bus.req_funct3 inside {3'd3, 3'd6, 3'd7});
        req_err    = misaligned || !in_range || illegal;
        // Store data is replicated so the byte-enables alone select the target lane.
        case (bus.req_funct3[1:0])
            2'b00:   st_data = {4{bus.req_wdata[7:0]}};
            2'b01:   st_data = {2{bus.req_wdata[15:0]}};
            default: st_data = bus.req_wdata;
        endcase
    end

    assign accept = bus.req_valid && ready_q;

`ifdef D_MEM_ZERO_INIT_EN
    logic [WA-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign init_we   = (state_q == ST_INIT);
    assign init_last = init_we && (cnt_q == WA'(DEPTH - 1));
    assign init_addr = cnt_q;
`else
    assign init_we   = 1'b0;
    assign init_last = 1'b0;
    assign init_addr = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RESET_ST;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_last) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.init_done = done_q;

    always_comb begin
        ram_en    = init_we || (accept && !req_err);
        ram_we    = init_we || bus.req_we;
        ram_be    = init_we ? 4'b1111 : be_mask(bus.req_funct3, lane);
        ram_addr  = init_we ? init_addr : word_idx;
        ram_wdata = init_we ? 32'h0 : st_data;
    end

    d_mem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_load_q  <= 1'b0;
            s1_f3_q    <= '0;
            s1_lane_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            s1_err_q   <= accept && req_err;
            s1_load_q  <= accept && !req_err && !bus.req_we;
            s1_f3_q    <= bus.req_funct3;
            s1_lane_q  <= lane;
        end
    end

    always_comb begin
        shifted = ram_rdata >> {s1_lane_q, 3'b000};
        case (s1_f3_q)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data = {24'h0, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {16'h0, shifted[15:0]};
            default: ld_data = ram_rdata;
        endcase
        // Stores, errors and idle cycles present zero data.
        s1_rdata = s1_load_q ? ld_data : 32'h0;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic        rsp_valid_q;
            logic        rsp_err_q;
            logic [31:0] rsp_rdata_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end else begin
                    rsp_valid_q <= s1_valid_q;
                    rsp_err_q   <= s1_err_q;
                    rsp_rdata_q <= s1_rdata;
                end
            end

            assign bus.rsp_valid = rsp_valid_q;
            assign bus.rsp_err   = rsp_err_q;
            assign bus.rsp_rdata = rsp_rdata_q;
        end else begin : g_out_direct
            assign bus.rsp_valid = s1_valid_q;
            assign bus.rsp_err   = s1_err_q;
            assign bus.rsp_rdata = s1_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_d_mem_ctrl.sv
// tb/tb_d_mem_ctrl.sv - randomized self-checking bench for d_mem_ctrl, OUT_REG=0 and OUT_REG=1 side by side
`timescale 1ns/1ps
module tb_d_mem_ctrl;
    import d_mem_pkg::*;

    localparam int          DEPTH = 16;
    localparam int          MBW   = $clog2(DEPTH * 4);
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam logic [2:0]  LD_F3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
`ifdef D_MEM_ZERO_INIT_EN
    localparam int          INIT_CYC = DEPTH;
`else
    localparam int          INIT_CYC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  mbytes [DEPTH*4];
    logic [32:0] exp_q[$];
    logic [32:0] got0_q[$];
    logic [32:0] got1_q[$];
    int          acc_q[$];
    int          cyc0_q[$];
    int          cyc1_q[$];

    d_mem_if #(.ADDR_W(32)) if0 ();
    d_mem_if #(.ADDR_W(32)) if1 ();

    assign if0.req_valid  = req_valid;
    assign if0.req_we     = req_we;
    assign if0.req_funct3 = req_funct3;
    assign if0.req_addr   = req_addr;
    assign if0.req_wdata  = req_wdata;
    assign if1.req_valid  = req_valid;
    assign if1.req_we     = req_we;
    assign if1.req_funct3 = req_funct3;
    assign if1.req_addr   = req_addr;
    assign if1.req_wdata  = req_wdata;

    d_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE), .OUT_REG(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    d_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE), .OUT_REG(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if0.rsp_valid === 1'b1) begin
            got0_q.push_back({if0.rsp_err, if0.rsp_rdata});
            cyc0_q.push_back(cyc);
        end
        if (if1.rsp_valid === 1'b1) begin
            got1_q.push_back({if1.rsp_err, if1.rsp_rdata});
            cyc1_q.push_back(cyc);
        end
    end

    // Byte-addressed reference: {err, rdata} for one access, applying stores to mbytes.
    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [32:0] rsp);
        int          nb;
        logic [31:0] off;
        logic [31:0] rd;
        logic        er;
        logic [MBW-1:0] bi;
        nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = addr - BASE;
        rd  = 32'h0;
        er  = (addr < BASE) || (off >= 32'(DEPTH * 4)) || ((addr % nb) != 0)
           || (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6));
        if (!er) begin
            for (int k = 0; k < nb; k++) begin
                bi = MBW'(off) + MBW'(k);
                if (we) mbytes[bi] = wd[8*k +: 8];
                else    rd[8*k +: 8] = mbytes[bi];
            end
            if (!we && !f3[2] && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8 * nb));
        end
        rsp = {er, rd};
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        logic [32:0] rsp;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        model_access(we, f3, addr, wd, rsp);
        exp_q.push_back(rsp);
        acc_q.push_back(cyc);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic flush();
        exp_q.delete();
        acc_q.delete();
        got0_q.delete();
        got1_q.delete();
        cyc0_q.delete();
        cyc1_q.delete();
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({if0.req_ready, if0.rsp_valid, if0.rsp_err, if0.init_done} !== 4'b0 || if0.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_out0 got rdy=%b v=%b e=%b done=%b d=%h want all 0", if0.req_ready,
                     if0.rsp_valid, if0.rsp_err, if0.init_done, if0.rsp_rdata);
        end
        checks++;
        if ({if1.req_ready, if1.rsp_valid, if1.rsp_err, if1.init_done} !== 4'b0 || if1.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_out1 got rdy=%b v=%b e=%b done=%b d=%h want all 0", if1.req_ready,
                     if1.rsp_valid, if1.rsp_err, if1.init_done, if1.rsp_rdata);
        end
        foreach (mbytes[b]) mbytes[b] = 8'h00;
        // A store held on the bus during INIT must be ignored.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = BASE;
        req_wdata  = 32'hA5A5_A5A5;
        rst = 1'b1;
        n = 0;
        while (if0.init_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        checks++;
        if (n != INIT_CYC) begin
            errors++;
            $display("FAIL init_len got %0d want %0d", n, INIT_CYC);
        end
        checks++;
        if (if0.req_ready !== 1'b1 || if1.req_ready !== 1'b1 || if1.init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_ready got rdy0=%b rdy1=%b done1=%b want 1", if0.req_ready,
                     if1.req_ready, if1.init_done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (got0_q.size() != 0 || got1_q.size() != 0) begin
            errors++;
            $display("FAIL init_ignore got %0d/%0d responses want 0", got0_q.size(), got1_q.size());
        end
        flush();
    endtask

    task automatic test_load_store();
`ifdef D_MEM_ZERO_INIT_EN
        issue(1'b0, F3_W, BASE + 32'h3C, 32'h0);
        issue(1'b0, F3_W, BASE, 32'h0);
`endif
        for (int w = 0; w < DEPTH; w++) issue(1'b1, F3_W, BASE + 32'(4 * w), $urandom);
        for (int w = 0; w < DEPTH; w++) issue(1'b0, F3_W, BASE + 32'(4 * w), 32'h0);
        issue(1'b1, F3_W,  BASE + 32'h4, 32'hDEAD_BEEF);
        issue(1'b0, F3_B,  BASE + 32'h7, 32'h0);
        issue(1'b0, F3_BU, BASE + 32'h4, 32'h0);
        issue(1'b0, F3_HU, BASE + 32'h6, 32'h0);
        issue(1'b1, F3_B,  BASE + 32'h5, 32'h0000_0012);
        issue(1'b0, F3_W,  BASE + 32'h4, 32'h0);
        issue(1'b0, F3_H,  BASE + 32'h6, 32'h0);
        for (int n = 0; n < 40; n++) begin
            logic        we;
            logic [2:0]  f3;
            int          sz;
            logic [31:0] a;
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 2)) : LD_F3[$urandom_range(0, 4)];
            sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            a  = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 7) != 0) a = a & ~32'(sz - 1);
            issue(we, f3, a, $urandom);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (got0_q.size() != exp_q.size() || got1_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ls_count got %0d/%0d want %0d", got0_q.size(), got1_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got0_q.size()) begin
                checks++;
                if (got0_q[i] !== exp_q[i] || cyc0_q[i] - acc_q[i] != 1) begin
                    errors++;
                    $display("FAIL ls_rsp0[%0d] got %h lat %0d want %h lat 1", i, got0_q[i],
                             cyc0_q[i] - acc_q[i], exp_q[i]);
                end
            end
            if (i < got1_q.size()) begin
                checks++;
                if (got1_q[i] !== exp_q[i] || cyc1_q[i] - acc_q[i] != 2) begin
                    errors++;
                    $display("FAIL ls_rsp1[%0d] got %h lat %0d want %h lat 2", i, got1_q[i],
                             cyc1_q[i] - acc_q[i], exp_q[i]);
                end
            end
        end
        flush();
    endtask

    task automatic test_errors();
        issue(1'b0, F3_W,  BASE + 32'h2, 32'h0);
        issue(1'b1, F3_H,  BASE + 32'h1, 32'h0000_AAAA);
        issue(1'b0, F3_W,  32'h0000_FFFC, 32'h0);
        issue(1'b0, 3'd3,  BASE + 32'h8, 32'h0);
        issue(1'b1, 3'd3,  BASE + 32'h8, 32'hFFFF_FFFF);
        issue(1'b1, F3_BU, BASE + 32'hC, 32'h5555_5555);
        issue(1'b1, F3_W,  BASE + 32'(DEPTH * 4), 32'h7777_7777);
        issue(1'b0, F3_B,  BASE + 32'(DEPTH * 4), 32'h0);
        issue(1'b0, 3'd6,  BASE, 32'h0);
        issue(1'b0, F3_W,  BASE, 32'h0);
        issue(1'b0, F3_W,  BASE + 32'h8, 32'h0);
        issue(1'b0, F3_W,  BASE + 32'hC, 32'h0);
        repeat (4) @(negedge clk);
        checks++;
        if (got0_q.size() != exp_q.size() || got1_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL err_count got %0d/%0d want %0d", got0_q.size(), got1_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got0_q.size()) begin
                checks++;
                if (got0_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL err_rsp0[%0d] got %h want %h", i, got0_q[i], exp_q[i]);
                end
            end
            if (i < got1_q.size()) begin
                checks++;
                if (got1_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL err_rsp1[%0d] got %h want %h", i, got1_q[i], exp_q[i]);
                end
            end
        end
        flush();
    endtask

    task automatic test_back_to_back();
        issue(1'b1, F3_B, BASE + 32'h9, $urandom);
        issue(1'b0, F3_W, BASE + 32'h8, 32'h0);
        issue(1'b1, F3_H, BASE + 32'hE, $urandom);
        issue(1'b0, F3_H, BASE + 32'hE, 32'h0);
        for (int n = 0; n < 8; n++) begin
            logic [2:0]  f3;
            int          sz;
            f3 = LD_F3[$urandom_range(0, 4)];
            sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            issue(1'b0, f3, (BASE + 32'($urandom_range(0, DEPTH * 4 - 1))) & ~32'(sz - 1), 32'h0);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (got0_q.size() != exp_q.size() || got1_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d/%0d want %0d", got0_q.size(), got1_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got0_q.size()) begin
                checks++;
                if (got0_q[i] !== exp_q[i] || cyc0_q[i] - acc_q[i] != 1) begin
                    errors++;
                    $display("FAIL b2b_rsp0[%0d] got %h lat %0d want %h lat 1", i, got0_q[i],
                             cyc0_q[i] - acc_q[i], exp_q[i]);
                end
            end
            if (i < got1_q.size()) begin
                checks++;
                if (got1_q[i] !== exp_q[i] || cyc1_q[i] - acc_q[i] != 2) begin
                    errors++;
                    $display("FAIL b2b_rsp1[%0d] got %h lat %0d want %h lat 2", i, got1_q[i],
                             cyc1_q[i] - acc_q[i], exp_q[i]);
                end
            end
        end
        flush();
    endtask

    task automatic test_reset_inflight();
        int n;
        issue(1'b0, F3_W, BASE + 32'h4, 32'h0);
        issue(1'b0, F3_W, BASE + 32'h8, 32'h0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (if0.rsp_valid !== 1'b0 || if1.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_clear got v0=%b v1=%b want 0", if0.rsp_valid, if1.rsp_valid);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (got0_q.size() != 2 || got1_q.size() != 1) begin
            errors++;
            $display("FAIL rst_inflight got %0d/%0d responses want 2/1", got0_q.size(), got1_q.size());
        end
        flush();
`ifdef D_MEM_ZERO_INIT_EN
        foreach (mbytes[b]) mbytes[b] = 8'h00;
`endif
        rst = 1'b1;
        n = 0;
        while (if0.init_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != INIT_CYC) begin
            errors++;
            $display("FAIL reinit_len got %0d want %0d", n, INIT_CYC);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (got0_q.size() != 0 || got1_q.size() != 0) begin
            errors++;
            $display("FAIL rst_late got %0d/%0d responses want 0", got0_q.size(), got1_q.size());
        end
`ifdef D_MEM_ZERO_INIT_EN
        issue(1'b0, F3_W, BASE + 32'h4, 32'h0);
        repeat (4) @(negedge clk);
        checks++;
        if (got0_q.size() != 1 || got1_q.size() != 1 || got0_q[0] !== exp_q[0] || got1_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL reinit_zero got %0d/%0d responses want 1/1 of %h", got0_q.size(),
                     got1_q.size(), exp_q[0]);
        end
`endif
        flush();
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_errors();
        test_back_to_back();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
